mem_wb_skid_stage: RTL and testbench

MEM_WB_SKID_STAGE -- requirements
Module: mem_wb_skid_stage

---
 rtl/mem_wb_skid_stage.sv | 139 +++++++++++++
 tb/tb_mem_wb_skid_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid_stage.sv
// mem_wb_skid_stage: two-entry skid buffer between the MEM and WB pipeline stages.
// Latency: one cycle from accept to out_* when the stage is empty or popping.
// Backpressure: in_ready is registered and drops only when both entries are held;
// it has no combinational path from out_ready.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   flush               synchronous kill of both buffered entries
//   in_valid/in_ready   upstream handshake; in_data/in_rd/in_link/in_wb_en/in_flags payload
//   out_valid/out_ready downstream handshake; out_* is the head (main) entry payload
//   out_wb_en           head writeback enable, gated by out_valid
//   occupancy           entries held (0..2)
//   stall_cycles        saturating count of cycles with out_valid=1 and out_ready=0
module mem_wb_skid_stage #(
   parameter int DATA_W  = 32,
   parameter int RD_W    = 4,
   parameter int FLAGS_W = 4,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [RD_W-1:0]    in_rd,
   input  logic               in_link,
   input  logic               in_wb_en,
   input  logic [FLAGS_W-1:0] in_flags,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic [RD_W-1:0]    out_rd,
   output logic               out_link,
   output logic               out_wb_en,
   output logic [FLAGS_W-1:0] out_flags,
   output logic [1:0]         occupancy,
   output logic [CNT_W-1:0]   stall_cycles
);

   typedef struct packed {
      logic [DATA_W-1:0]  data;
      logic [RD_W-1:0]    rd;
      logic               link;
      logic               wb_en;
      logic [FLAGS_W-1:0] flags;
   } entry_t;

   // Encodings double as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t state;
   entry_t main_ent;
   entry_t skid_ent;
   entry_t in_ent;
   logic   main_vld;
   logic   skid_vld;
   logic   accept;
   logic   pop;

   assign in_ent = '{data: in_data, rd: in_rd, link: in_link, wb_en: in_wb_en, flags: in_flags};
   assign accept = in_valid & in_ready;
   assign pop    = main_vld & out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= EMPTY;
         main_vld     <= 1'b0;
         skid_vld     <= 1'b0;
         in_ready     <= 1'b1;
         main_ent     <= '0;
         skid_ent     <= '0;
         stall_cycles <= '0;
      end else begin
         // Back-pressured cycles count regardless of flush; saturate, never wrap.
         if (main_vld && !out_ready && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;

         if (flush) begin
            // Flush beats any same-cycle accept or pop; payload left as-is.
            state    <= EMPTY;
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            in_ready <= 1'b1;
         end else begin
            case (state)
               EMPTY: begin
                  if (accept) begin
                     main_ent <= in_ent;
                     main_vld <= 1'b1;
                     state    <= ONE;
                  end
               end
               ONE: begin
                  if (accept && pop) begin
                     main_ent <= in_ent;
                  end else if (accept) begin
                     skid_ent <= in_ent;
                     skid_vld <= 1'b1;
                     in_ready <= 1'b0;
                     state    <= TWO;
                  end else if (pop) begin
                     main_vld <= 1'b0;
                     state    <= EMPTY;
                  end
               end
               TWO: begin
                  // in_ready is low here, so no accept can occur.
                  if (pop) begin
                     main_ent <= skid_ent;
                     skid_vld <= 1'b0;
                     in_ready <= 1'b1;
                     state    <= ONE;
                  end
               end
               default: begin
                  state    <= EMPTY;
                  main_vld <= 1'b0;
                  skid_vld <= 1'b0;
                  in_ready <= 1'b1;
               end
            endcase
         end
      end
   end

   assign out_valid = main_vld;
   assign out_data  = main_ent.data;
   assign out_rd    = main_ent.rd;
   assign out_link  = main_ent.link;
   assign out_flags = main_ent.flags;
   assign out_wb_en = main_ent.wb_en & main_vld;
   assign occupancy = state;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
module tb_mem_wb_skid_stage;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready, in_link, in_wb_en;
   logic [31:0] in_data;
   logic [3:0]  in_rd, in_flags;
   logic        out_valid, out_ready, out_link, out_wb_en;
   logic [31:0] out_data;
   logic [3:0]  out_rd, out_flags;
   logic [1:0]  occupancy;
   logic [3:0]  stall_cycles;

   always #5 clk = ~clk;

   mem_wb_skid_stage #(.DATA_W(32), .RD_W(4), .FLAGS_W(4), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rd(in_rd),
      .in_link(in_link), .in_wb_en(in_wb_en), .in_flags(in_flags),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
      .out_link(out_link), .out_wb_en(out_wb_en), .out_flags(out_flags),
      .occupancy(occupancy), .stall_cycles(stall_cycles)
   );

   typedef struct {
      logic [31:0] data;
      logic [3:0]  rd;
      logic        link;
      logic        wb;
      logic [3:0]  flags;
   } ent_t;

   typedef struct {
      logic        fl;
      logic        iv;
      logic [31:0] d;
      logic        ordy;
      logic        ov;
      logic [31:0] od;
      logic [1:0]  occ;
      logic        ir;
      logic [3:0]  st;
   } vec_t;

   int   n_vec = 0;
   int   n_err = 0;
   ent_t sb_q[$];
   logic exp_rdy;
   vec_t vt[21];

   // Side-band fields derived from the data word so each entry is distinguishable.
   function automatic ent_t mk_ent(input logic [31:0] d);
      ent_t e;
      e.data  = d;
      e.rd    = d[3:0];
      e.flags = d[7:4];
      e.link  = d[0];
      e.wb    = d[1];
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
      ent_t e;
      e = mk_ent(d);
      flush = fl; in_valid = iv; out_ready = ordy;
      in_data = e.data; in_rd = e.rd; in_link = e.link; in_wb_en = e.wb; in_flags = e.flags;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input vec_t v, input int idx);
      ent_t e;
      drive(v.fl, v.iv, v.d, v.ordy);
      #1;
      // Pop side: whatever the DUT presents while being consumed must be the queue head.
      if (out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            check($sformatf("v%0d sb_underflow", idx), 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check($sformatf("v%0d sb_data", idx), out_data, e.data);
            check($sformatf("v%0d sb_rd", idx), {28'd0, out_rd}, {28'd0, e.rd});
            check($sformatf("v%0d sb_link", idx), {31'd0, out_link}, {31'd0, e.link});
            check($sformatf("v%0d sb_wb_en", idx), {31'd0, out_wb_en}, {31'd0, e.wb});
            check($sformatf("v%0d sb_flags", idx), {28'd0, out_flags}, {28'd0, e.flags});
         end
      end
      if (v.fl) sb_q.delete();
      else if (v.iv && exp_rdy) sb_q.push_back(mk_ent(v.d));
      tick();
      check($sformatf("v%0d out_valid", idx), {31'd0, out_valid}, {31'd0, v.ov});
      if (v.ov) check($sformatf("v%0d out_data", idx), out_data, v.od);
      else check($sformatf("v%0d out_wb_en_idle", idx), {31'd0, out_wb_en}, 32'd0);
      check($sformatf("v%0d occupancy", idx), {30'd0, occupancy}, {30'd0, v.occ});
      check($sformatf("v%0d in_ready", idx), {31'd0, in_ready}, {31'd0, v.ir});
      check($sformatf("v%0d stall", idx), {28'd0, stall_cycles}, {28'd0, v.st});
      exp_rdy = v.ir;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, " out_wb_en"}, {31'd0, out_wb_en}, 32'd0);
      check({tag, " out_data"}, out_data, 32'd0);
      check({tag, " out_rd"}, {28'd0, out_rd}, 32'd0);
      check({tag, " out_link"}, {31'd0, out_link}, 32'd0);
      check({tag, " out_flags"}, {28'd0, out_flags}, 32'd0);
      check({tag, " occupancy"}, {30'd0, occupancy}, 32'd0);
      check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
      check({tag, " stall"}, {28'd0, stall_cycles}, 32'd0);
   endtask

   initial begin
      //          fl    iv    data    ordy  ov    od      occ   ir    st
      vt[0]  = '{1'b0, 1'b1, 32'h11, 1'b1, 1'b1, 32'h11, 2'd1, 1'b1, 4'd0};  // stream
      vt[1]  = '{1'b0, 1'b1, 32'h22, 1'b1, 1'b1, 32'h22, 2'd1, 1'b1, 4'd0};
      vt[2]  = '{1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 32'h33, 2'd1, 1'b1, 4'd0};
      vt[3]  = '{1'b0, 1'b1, 32'h44, 1'b1, 1'b1, 32'h44, 2'd1, 1'b1, 4'd0};
      vt[4]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 2'd0, 1'b1, 4'd0};
      vt[5]  = '{1'b0, 1'b1, 32'h0A, 1'b0, 1'b1, 32'h0A, 2'd1, 1'b1, 4'd0};  // back-pressure
      vt[6]  = '{1'b0, 1'b1, 32'h0B, 1'b0, 1'b1, 32'h0A, 2'd2, 1'b0, 4'd1};
      vt[7]  = '{1'b0, 1'b1, 32'h0C, 1'b0, 1'b1, 32'h0A, 2'd2, 1'b0, 4'd2};
      vt[8]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h0B, 2'd1, 1'b1, 4'd2};
      vt[9]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 2'd0, 1'b1, 4'd2};
      vt[10] = '{1'b0, 1'b1, 32'h01, 1'b0, 1'b1, 32'h01, 2'd1, 1'b1, 4'd2};  // flush in TWO
      vt[11] = '{1'b0, 1'b1, 32'h02, 1'b0, 1'b1, 32'h01, 2'd2, 1'b0, 4'd3};
      vt[12] = '{1'b1, 1'b1, 32'h55, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1, 4'd4};
      vt[13] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 2'd0, 1'b1, 4'd4};
      vt[14] = '{1'b0, 1'b1, 32'h66, 1'b1, 1'b1, 32'h66, 2'd1, 1'b1, 4'd4};  // flush + pop
      vt[15] = '{1'b1, 1'b1, 32'h77, 1'b1, 1'b0, 32'h00, 2'd0, 1'b1, 4'd4};
      vt[16] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 2'd0, 1'b1, 4'd4};
      vt[17] = '{1'b0, 1'b1, 32'h88, 1'b0, 1'b1, 32'h88, 2'd1, 1'b1, 4'd4};  // ONE hold
      vt[18] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 32'h88, 2'd1, 1'b1, 4'd5};
      vt[19] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 2'd0, 1'b1, 4'd5};
      vt[20] = '{1'b1, 1'b1, 32'h99, 1'b1, 1'b0, 32'h00, 2'd0, 1'b1, 4'd5};  // flush in EMPTY

      reset = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      tick(); tick();
      check_reset_state("reset");
      reset = 1'b0;
      exp_rdy = 1'b1;

      for (int i = 0; i < 21; i++) apply(vt[i], i);
      check("sb_empty_after_table", sb_q.size(), 32'd0);

      // Writeback gating: entry shows one cycle while popped, then disappears.
      drive(1'b0, 1'b1, 32'hDEAD_BEE0, 1'b1);
      in_rd = 4'hE; in_link = 1'b1; in_wb_en = 1'b1; in_flags = 4'hA;
      tick();
      check("gate out_valid", {31'd0, out_valid}, 32'd1);
      check("gate out_wb_en", {31'd0, out_wb_en}, 32'd1);
      check("gate out_rd", {28'd0, out_rd}, 32'hE);
      check("gate out_link", {31'd0, out_link}, 32'd1);
      check("gate out_flags", {28'd0, out_flags}, 32'hA);
      check("gate out_data", out_data, 32'hDEAD_BEE0);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      check("gate out_valid_after", {31'd0, out_valid}, 32'd0);
      check("gate out_wb_en_after", {31'd0, out_wb_en}, 32'd0);

      // Stall counter saturation, then survival across flush.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive(1'b0, 1'b1, 32'h123, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      for (int c = 0; c < 14; c++) tick();
      check("sat stall_14", {28'd0, stall_cycles}, 32'd14);
      for (int c = 0; c < 6; c++) tick();
      check("sat stall_20", {28'd0, stall_cycles}, 32'd15);
      check("sat out_data_held", out_data, 32'h123);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("sat stall_after_flush", {28'd0, stall_cycles}, 32'd15);
      check("sat out_valid_after_flush", {31'd0, out_valid}, 32'd0);

      // Reset with flush while both entries are held.
      drive(1'b0, 1'b1, 32'hAB, 1'b0);
      tick();
      drive(1'b0, 1'b1, 32'hCD, 1'b0);
      tick();
      check("two occupancy", {30'd0, occupancy}, 32'd2);
      check("two in_ready", {31'd0, in_ready}, 32'd0);
      drive(1'b1, 1'b1, 32'hEF, 1'b1);
      reset = 1'b1;
      tick();
      check_reset_state("reset_in_two");
      reset = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      check("post_reset out_valid", {31'd0, out_valid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
